// File: rtl/fsm_stream_arbiter_if.sv
// rtl/fsm_stream_arbiter_if.sv - request/response bus between requesters, arbiter and result consumer
interface fsm_stream_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
);
  logic [1:0]       req_valid;
  logic [WIDTH-1:0] req_data0;
  logic [WIDTH-1:0] req_data1;
  logic [1:0]       req_ready;
  logic             rsp_valid;
  logic             rsp_id;
  logic [CW-1:0]    rsp_z1_cnt;
  logic [CW-1:0]    rsp_z2_cnt;
  logic             rsp_ready;

  modport master (
    output req_valid, req_data0, req_data1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_z1_cnt, rsp_z2_cnt
  );

  modport slave (
    input  req_valid, req_data0, req_data1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_z1_cnt, rsp_z2_cnt
  );
endinterface

// File: rtl/fsm_stream_arbiter.sv
// rtl/fsm_stream_arbiter.sv - round-robin arbiter serialising two requesters' words into a shared sequence detector
module fsm_stream_arbiter #(
  parameter int WIDTH      = 8,
  parameter int CLR_CYCLES = 1,
  parameter int CW         = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fsm_stream_arbiter_if.slave  bus,
  output logic                 det_rst_n,
  output logic                 det_x,
  input  logic                 det_z1,
  input  logic                 det_z2,
  output logic                 busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [15:0] CLR_LAST   = 16'(CLR_CYCLES - 1);
  localparam logic [15:0] SHIFT_LAST = 16'(WIDTH - 1);

  logic [2:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [15:0]      timer;
  logic             last;
  logic             rst_q;
  logic [1:0]       ready_q;
  logic             id_q;
  logic [CW-1:0]    z1_cnt;
  logic [CW-1:0]    z2_cnt;
  logic             grant_id;
  logic             sample;

  // Tie goes to the requester not served last; a lone requester always wins.
  always_comb begin
    grant_id = 1'b0;
    if (bus.req_valid == 2'b11) grant_id = ~last;
    else                        grant_id = bus.req_valid[1];
  end

  // The detector output is registered, so the first SHIFT cycle still shows the cleared state.
  assign sample = ((state == S_SHIFT) && (timer != 16'd0)) || (state == S_DRAIN);

  always_ff @(posedge clk) begin
    rst_q <= reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      sreg    <= '0;
      timer   <= '0;
      last    <= 1'b1;
      ready_q <= 2'b00;
      id_q    <= 1'b0;
      z1_cnt  <= '0;
      z2_cnt  <= '0;
    end else begin
      ready_q <= 2'b00;
      if (sample) begin
        if (det_z1 && (z1_cnt != '1)) z1_cnt <= z1_cnt + CW'(1);
        if (det_z2 && (z2_cnt != '1)) z2_cnt <= z2_cnt + CW'(1);
      end
      case (state)
        S_IDLE: begin
          if (|bus.req_valid) begin
            ready_q <= grant_id ? 2'b10 : 2'b01;
            id_q    <= grant_id;
            sreg    <= grant_id ? bus.req_data1 : bus.req_data0;
            z1_cnt  <= '0;
            z2_cnt  <= '0;
            timer   <= '0;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (timer == CLR_LAST) begin
            timer <= '0;
            state <= S_SHIFT;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_SHIFT: begin
          sreg <= sreg << 1;
          if (timer == SHIFT_LAST) begin
            timer <= '0;
            state <= S_DRAIN;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_DRAIN: state <= S_RESP;
        S_RESP: begin
          if (bus.rsp_ready) begin
            last  <= id_q;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.rsp_valid  = (state == S_RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_z1_cnt = z1_cnt;
  assign bus.rsp_z2_cnt = z2_cnt;
  assign busy           = (state != S_IDLE);
  assign det_x          = (state == S_SHIFT) && sreg[WIDTH-1];
  // Held low during reset via rst_q so the detector also restarts on a system reset.
  assign det_rst_n      = !(rst_q || (state == S_CLEAR));

endmodule

// File: doc/fsm_stream_arbiter.md
FSM_STREAM_ARBITER -- requirements
Module: fsm_stream_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: bits per request word, serialised MSB first.
REQ-002 Parameter CLR_CYCLES, default 1: cycles det_rst_n is held low before each word.
REQ-003 Parameter CW, default 4: count width, shall satisfy 2^CW > WIDTH.
REQ-004 Port clk  in  1  sole clock, all logic on posedge.
REQ-005 Port reset  in  1  synchronous, active-high.
REQ-006 Port req_valid  in  2  requester n has a word pending.
REQ-007 Port req_data0 / req_data1  in  WIDTH each  words of requesters 0 and 1.
REQ-008 Port req_ready  out  2  one-cycle accept pulse, at most one bit high.
REQ-009 Port det_rst_n  out  1  active-low reset to the shared sequence detector.
REQ-010 Port det_x  out  1  serial input bit X to the detector.
REQ-011 Port det_z1 / det_z2  in  1 each  detector outputs Z1/Z2, registered (Moore).
REQ-012 Port rsp_valid  out  1  result available.
REQ-013 Port rsp_id  out  1  index of the served requester.
REQ-014 Port rsp_z1_cnt / rsp_z2_cnt  out  CW each  number of sampled cycles with Z1 / Z2 high.
REQ-015 Port rsp_ready  in  1  consumer accepts the result.
REQ-016 Port busy  out  1  high in every state except IDLE.

Function
REQ-017 The FSM shall have exactly the states IDLE, CLEAR, SHIFT, DRAIN and RESP.
REQ-018 IDLE: if any req_valid bit is high, grant one requester, pulse its req_ready for that cycle, latch its data into the shift register, clear both counts, then go to CLEAR.
REQ-019 Arbitration shall be round-robin: if both are valid, the requester not served last wins; if one is valid, it wins regardless of history.
REQ-020 The last-served pointer shall update on the RESP handshake, not at grant.
REQ-021 CLEAR: det_rst_n=0 and det_x=0 for exactly CLR_CYCLES cycles, then go to SHIFT.
REQ-022 SHIFT: det_rst_n=1 and det_x=shift-register MSB, shifting left one bit per cycle, for exactly WIDTH cycles, then go to DRAIN.
REQ-023 DRAIN: one cycle with det_x=0, then go to RESP.
REQ-024 Sampling: det_z1/det_z2 shall be sampled in SHIFT cycles 2..WIDTH and the DRAIN cycle (WIDTH samples).
REQ-025 Each count shall increment by 1 per sampled cycle with its input high, and shall not wrap.
REQ-026 RESP: rsp_valid=1, with rsp_id and both counts held stable until the cycle rsp_ready=1.
REQ-027 On the RESP handshake, go to IDLE with rsp_valid=0 the following cycle.
REQ-028 Latency from the req_ready pulse to the first rsp_valid cycle shall be CLR_CYCLES+WIDTH+1 cycles.
REQ-029 Minimum spacing between consecutive grants shall be CLR_CYCLES+WIDTH+3 cycles, with rsp_ready held high.
REQ-030 Outside IDLE, req_valid shall be ignored and req_ready shall be 0.
REQ-031 Outside RESP, rsp_ready shall be ignored.
REQ-032 Words shall not be queued internally: a requester keeps req_valid high until it sees req_ready.
REQ-033 In IDLE and RESP, det_rst_n=1 and det_x=0.

Reset
REQ-034 reset=1 at a posedge shall force IDLE and set req_ready=0, det_rst_n=0, det_x=0, rsp_valid=0, rsp_id=0, both counts 0, busy=0 and the pointer so that requester 0 wins the first tie.
REQ-035 Reset asserted mid-operation (any state) shall abort the word with no response and no further req_ready.
REQ-036 det_rst_n shall return to 1 in the first cycle after reset deasserts.

Verification
Bench detector stub: Z1 = X registered; Z2 = high when the last two registered X samples are both 1; the stub resets on det_rst_n.
REQ-037 Single word: req_valid=01, data0=0xFF -> req_ready=01 pulse, rsp_valid 10 cycles later, rsp_id=0, z1=8, z2=7.
REQ-038 Pattern: data1=0xA5 alone -> rsp_id=1, z1=4, z2=0; data 0x0F -> z1=4, z2=3.
REQ-039 Tie: req_valid=11 held, rsp_ready=1 -> grants alternate 0,1,0,1; each grant spaced 12 cycles.
REQ-040 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and counts stable for all 5 cycles; no req_ready while the other requester is valid.
REQ-041 Abort: reset asserted in SHIFT cycle 4 -> the next cycle shows all outputs at reset values; a new word afterwards yields correct counts.
REQ-042 Serial check: data=0xA5 -> det_x over SHIFT cycles reads 1,0,1,0,0,1,0,1; det_rst_n low for exactly 1 cycle before them.
